// File: rtl/id_ex_issue_buffer.sv
// id_ex_issue_buffer: two independent 2-deep decode-to-execute skid FIFOs with flush.
// Optional per-lane stall counters are built only when ISSUE_BUF_STATS_EN is defined.
module id_ex_issue_buffer (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid_1,
  input  logic [63:0] id_NPC_1,
  input  logic [31:0] id_IR_1,
  input  logic [4:0]  id_dest_reg_1,
  input  logic [63:0] id_rega_1,
  input  logic [63:0] id_regb_1,
  input  logic [1:0]  id_opa_select_1,
  input  logic [1:0]  id_opb_select_1,
  input  logic [4:0]  id_alu_func_1,
  input  logic        id_cond_branch,
  input  logic        id_uncond_branch,
  input  logic        id_valid_2,
  input  logic [63:0] id_NPC_2,
  input  logic [31:0] id_IR_2,
  input  logic [4:0]  id_dest_reg_2,
  input  logic [63:0] id_rega_2,
  input  logic [63:0] id_regb_2,
  input  logic [1:0]  id_opa_select_2,
  input  logic [1:0]  id_opb_select_2,
  input  logic [4:0]  id_alu_func_2,
  input  logic        stall_bus_1,
  input  logic        stall_bus_2,
  input  logic        ex_branch_taken,
  output logic        id_ready_1,
  output logic        id_ready_2,
  output logic        id_ex_valid_1,
  output logic [63:0] id_ex_NPC_1,
  output logic [31:0] id_ex_IR_1,
  output logic [4:0]  id_ex_dest_reg_1,
  output logic [63:0] id_ex_rega_1,
  output logic [63:0] id_ex_regb_1,
  output logic [1:0]  id_ex_opa_select_1,
  output logic [1:0]  id_ex_opb_select_1,
  output logic [4:0]  id_ex_alu_func_1,
  output logic        id_ex_cond_branch,
  output logic        id_ex_uncond_branch,
  output logic        id_ex_valid_2,
  output logic [63:0] id_ex_NPC_2,
  output logic [31:0] id_ex_IR_2,
  output logic [4:0]  id_ex_dest_reg_2,
  output logic [63:0] id_ex_rega_2,
  output logic [63:0] id_ex_regb_2,
  output logic [1:0]  id_ex_opa_select_2,
  output logic [1:0]  id_ex_opb_select_2,
  output logic [4:0]  id_ex_alu_func_2,
  output logic [31:0] stall_cycles_1,
  output logic [31:0] stall_cycles_2
);
  typedef struct packed {
    logic [63:0] npc;
    logic [31:0] ir;
    logic [4:0]  dest;
    logic [63:0] rega;
    logic [63:0] regb;
    logic [1:0]  opa;
    logic [1:0]  opb;
    logic [4:0]  alu;
  } entry_t;
  localparam entry_t NOP = '{npc: '0, ir: 32'h47ff041f, dest: 5'd31, rega: '0, regb: '0,
                             opa: '0, opb: '0, alu: '0};
  entry_t in_e [2];
  entry_t out_e [2];
  logic [31:0] stat [2];
  logic [1:0] valid_in, stall, push, pop, ready, valid_out, br;
  logic flush;
  assign flush = ex_branch_taken;
  assign valid_in = {id_valid_2, id_valid_1};
  assign stall = {stall_bus_2, stall_bus_1};
  assign in_e[0] = '{id_NPC_1, id_IR_1, id_dest_reg_1, id_rega_1, id_regb_1,
                     id_opa_select_1, id_opb_select_1, id_alu_func_1};
  assign in_e[1] = '{id_NPC_2, id_IR_2, id_dest_reg_2, id_rega_2, id_regb_2,
                     id_opa_select_2, id_opb_select_2, id_alu_func_2};
  for (genvar g = 0; g < 2; g++) begin : g_lane
    entry_t head, skid;
    logic [1:0] cnt;
    assign ready[g] = cnt != 2'd2;
    assign valid_out[g] = cnt != 2'd0;
    assign push[g] = valid_in[g] & ready[g] & !flush;
    assign pop[g] = valid_out[g] & !stall[g] & !flush;
    assign out_e[g] = valid_out[g] ? head : NOP;
    always_ff @(posedge clock or negedge reset)
      if (!reset) cnt <= '0;
      else cnt <= flush ? 2'd0 : cnt + {1'b0, push[g]} - {1'b0, pop[g]};
    // Payload needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clock) begin
      if (pop[g]) head <= cnt == 2'd2 ? skid : in_e[g];
      else if (push[g] && cnt == 2'd0) head <= in_e[g];
      if (push[g] && !pop[g] && cnt == 2'd1) skid <= in_e[g];
    end
    if (g == 0) begin : g_br
      logic [1:0] br_in, br_skid;
      assign br_in = {id_cond_branch, id_uncond_branch};
      always_ff @(posedge clock) begin
        if (pop[0]) br <= cnt == 2'd2 ? br_skid : br_in;
        else if (push[0] && cnt == 2'd0) br <= br_in;
        if (push[0] && !pop[0] && cnt == 2'd1) br_skid <= br_in;
      end
    end
`ifdef ISSUE_BUF_STATS_EN
    logic [31:0] sc;
    always_ff @(posedge clock or negedge reset)
      if (!reset) sc <= '0;
      else if (valid_out[g] && stall[g] && sc != '1) sc <= sc + 32'd1;
    assign stat[g] = sc;
`else
    assign stat[g] = '0;
`endif
  end
  assign id_ready_1 = ready[0];
  assign id_ready_2 = ready[1];
  assign id_ex_valid_1 = valid_out[0];
  assign id_ex_valid_2 = valid_out[1];
  assign id_ex_cond_branch = valid_out[0] & br[1];
  assign id_ex_uncond_branch = valid_out[0] & br[0];
  assign id_ex_NPC_1 = out_e[0].npc;
  assign id_ex_IR_1 = out_e[0].ir;
  assign id_ex_dest_reg_1 = out_e[0].dest;
  assign id_ex_rega_1 = out_e[0].rega;
  assign id_ex_regb_1 = out_e[0].regb;
  assign id_ex_opa_select_1 = out_e[0].opa;
  assign id_ex_opb_select_1 = out_e[0].opb;
  assign id_ex_alu_func_1 = out_e[0].alu;
  assign id_ex_NPC_2 = out_e[1].npc;
  assign id_ex_IR_2 = out_e[1].ir;
  assign id_ex_dest_reg_2 = out_e[1].dest;
  assign id_ex_rega_2 = out_e[1].rega;
  assign id_ex_regb_2 = out_e[1].regb;
  assign id_ex_opa_select_2 = out_e[1].opa;
  assign id_ex_opb_select_2 = out_e[1].opb;
  assign id_ex_alu_func_2 = out_e[1].alu;
  assign stall_cycles_1 = stat[0];
  assign stall_cycles_2 = stat[1];
endmodule

// File: tb/tb_id_ex_issue_buffer.sv
// tb_id_ex_issue_buffer: directed self-checking bench for id_ex_issue_buffer.
module tb_id_ex_issue_buffer;
  logic clock = 0, reset = 0;
  always #5 clock = ~clock;
  logic id_valid_1, id_valid_2, id_cond_branch, id_uncond_branch;
  logic [63:0] id_NPC_1, id_NPC_2, id_rega_1, id_rega_2, id_regb_1, id_regb_2;
  logic [31:0] id_IR_1, id_IR_2;
  logic [4:0] id_dest_reg_1, id_dest_reg_2, id_alu_func_1, id_alu_func_2;
  logic [1:0] id_opa_select_1, id_opa_select_2, id_opb_select_1, id_opb_select_2;
  logic stall_bus_1, stall_bus_2, ex_branch_taken;
  logic id_ready_1, id_ready_2, id_ex_valid_1, id_ex_valid_2, id_ex_cond_branch, id_ex_uncond_branch;
  logic [63:0] id_ex_NPC_1, id_ex_NPC_2, id_ex_rega_1, id_ex_rega_2, id_ex_regb_1, id_ex_regb_2;
  logic [31:0] id_ex_IR_1, id_ex_IR_2, stall_cycles_1, stall_cycles_2;
  logic [4:0] id_ex_dest_reg_1, id_ex_dest_reg_2, id_ex_alu_func_1, id_ex_alu_func_2;
  logic [1:0] id_ex_opa_select_1, id_ex_opa_select_2, id_ex_opb_select_1, id_ex_opb_select_2;
  localparam logic [63:0] NOP = 64'h47ff041f;
`ifdef ISSUE_BUF_STATS_EN
  localparam logic [63:0] SC5 = 64'd5;
`else
  localparam logic [63:0] SC5 = 64'd0;
`endif
  int checks = 0, failures = 0;
  id_ex_issue_buffer dut (
    .clock(clock), .reset(reset),
    .id_valid_1(id_valid_1), .id_NPC_1(id_NPC_1), .id_IR_1(id_IR_1), .id_dest_reg_1(id_dest_reg_1),
    .id_rega_1(id_rega_1), .id_regb_1(id_regb_1), .id_opa_select_1(id_opa_select_1),
    .id_opb_select_1(id_opb_select_1), .id_alu_func_1(id_alu_func_1),
    .id_cond_branch(id_cond_branch), .id_uncond_branch(id_uncond_branch),
    .id_valid_2(id_valid_2), .id_NPC_2(id_NPC_2), .id_IR_2(id_IR_2), .id_dest_reg_2(id_dest_reg_2),
    .id_rega_2(id_rega_2), .id_regb_2(id_regb_2), .id_opa_select_2(id_opa_select_2),
    .id_opb_select_2(id_opb_select_2), .id_alu_func_2(id_alu_func_2),
    .stall_bus_1(stall_bus_1), .stall_bus_2(stall_bus_2), .ex_branch_taken(ex_branch_taken),
    .id_ready_1(id_ready_1), .id_ready_2(id_ready_2),
    .id_ex_valid_1(id_ex_valid_1), .id_ex_NPC_1(id_ex_NPC_1), .id_ex_IR_1(id_ex_IR_1),
    .id_ex_dest_reg_1(id_ex_dest_reg_1), .id_ex_rega_1(id_ex_rega_1), .id_ex_regb_1(id_ex_regb_1),
    .id_ex_opa_select_1(id_ex_opa_select_1), .id_ex_opb_select_1(id_ex_opb_select_1),
    .id_ex_alu_func_1(id_ex_alu_func_1), .id_ex_cond_branch(id_ex_cond_branch),
    .id_ex_uncond_branch(id_ex_uncond_branch),
    .id_ex_valid_2(id_ex_valid_2), .id_ex_NPC_2(id_ex_NPC_2), .id_ex_IR_2(id_ex_IR_2),
    .id_ex_dest_reg_2(id_ex_dest_reg_2), .id_ex_rega_2(id_ex_rega_2), .id_ex_regb_2(id_ex_regb_2),
    .id_ex_opa_select_2(id_ex_opa_select_2), .id_ex_opb_select_2(id_ex_opb_select_2),
    .id_ex_alu_func_2(id_ex_alu_func_2),
    .stall_cycles_1(stall_cycles_1), .stall_cycles_2(stall_cycles_2)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic drive1(input logic v, input logic [31:0] ir, input logic [63:0] npc, input logic cb);
    id_valid_1 = v;
    id_IR_1 = ir;
    id_NPC_1 = npc;
    id_cond_branch = cb;
  endtask
  task automatic drive2(input logic v, input logic [31:0] ir, input logic [63:0] npc);
    id_valid_2 = v;
    id_IR_2 = ir;
    id_NPC_2 = npc;
  endtask
  initial begin
    drive1(0, 0, 0, 0);
    drive2(0, 0, 0);
    id_uncond_branch = 0;
    id_dest_reg_1 = 5'd7; id_rega_1 = 64'h1111; id_regb_1 = 64'h1234; id_opa_select_1 = 2'd1;
    id_opb_select_1 = 2'd2; id_alu_func_1 = 5'h0a;
    id_dest_reg_2 = 5'd9; id_rega_2 = 64'h2222; id_regb_2 = 64'h5678; id_opa_select_2 = 2'd3;
    id_opb_select_2 = 2'd1; id_alu_func_2 = 5'h15;
    stall_bus_1 = 0; stall_bus_2 = 0; ex_branch_taken = 0;
    #12;
    check("rst_valid1", id_ex_valid_1, 0);
    check("rst_valid2", id_ex_valid_2, 0);
    check("rst_ir1", id_ex_IR_1, NOP);
    check("rst_ir2", id_ex_IR_2, NOP);
    check("rst_dest1", id_ex_dest_reg_1, 31);
    check("rst_npc2", id_ex_NPC_2, 0);
    check("rst_ready", {id_ready_1, id_ready_2}, 2'b11);
    check("rst_sc", {stall_cycles_1, stall_cycles_2}, 0);
    reset = 1;
    drive1(1, 32'h40010402, 64'h4, 0);
    step;
    check("p1_ir", id_ex_IR_1, 64'h40010402);
    check("p1_valid", id_ex_valid_1, 1);
    check("p1_npc", id_ex_NPC_1, 4);
    check("p1_fields", {id_ex_dest_reg_1, id_ex_opa_select_1, id_ex_opb_select_1, id_ex_alu_func_1},
          {5'd7, 2'd1, 2'd2, 5'h0a});
    check("p1_rega", id_ex_rega_1, 64'h1111);
    check("p1_lane2_idle", id_ex_valid_2, 0);
    drive1(0, 0, 0, 0);
    step;
    check("p1_drain_valid", id_ex_valid_1, 0);
    check("p1_drain_ir", id_ex_IR_1, NOP);
    check("p1_drain_rega", id_ex_rega_1, 0);
    stall_bus_1 = 1;
    drive1(1, 32'hA0000001, 64'h8, 1);
    step;
    check("stA_ir", id_ex_IR_1, 64'hA0000001);
    check("stA_cb", id_ex_cond_branch, 1);
    check("stA_ready", id_ready_1, 1);
    drive1(1, 32'hB0000002, 64'hC, 0);
    step;
    check("stB_ir_held", id_ex_IR_1, 64'hA0000001);
    check("stB_ready", id_ready_1, 0);
    drive1(0, 0, 0, 0);
    step;
    check("st_hold_ir", id_ex_IR_1, 64'hA0000001);
    check("st_hold_npc", id_ex_NPC_1, 8);
    stall_bus_1 = 0;
    step;
    check("rel_ir_B", id_ex_IR_1, 64'hB0000002);
    check("rel_cb_B", id_ex_cond_branch, 0);
    check("rel_ready", id_ready_1, 1);
    step;
    check("rel_empty", id_ex_valid_1, 0);
    drive2(1, 32'h11110000, 64'h20);
    step;
    check("pp_x_ir", id_ex_IR_2, 64'h11110000);
    drive2(1, 32'hC0C0C0C0, 64'h24);
    step;
    check("pp_c_ir", id_ex_IR_2, 64'hC0C0C0C0);
    check("pp_c_npc", id_ex_NPC_2, 64'h24);
    check("pp_ready", id_ready_2, 1);
    drive2(0, 0, 0);
    step;
    check("pp_occ1", id_ex_valid_2, 0);
    stall_bus_1 = 1; stall_bus_2 = 1;
    drive1(1, 32'hD1, 64'h30, 0);
    drive2(1, 32'hD2, 64'h40);
    step;
    drive1(1, 32'hE1, 64'h34, 0);
    drive2(1, 32'hE2, 64'h44);
    step;
    check("full_ready", {id_ready_1, id_ready_2}, 2'b00);
    check("full_heads", {id_ex_IR_1, id_ex_IR_2}, {32'hD1, 32'hD2});
    drive1(0, 0, 0, 0);
    drive2(1, 32'hF2, 64'h48);
    ex_branch_taken = 1;
    step;
    check("fl_valid", {id_ex_valid_1, id_ex_valid_2}, 2'b00);
    check("fl_ready", {id_ready_1, id_ready_2}, 2'b11);
    check("fl_ir2", id_ex_IR_2, NOP);
    step;
    check("fl_push_absent", id_ex_valid_2, 0);
    ex_branch_taken = 0;
    drive2(0, 0, 0);
    step;
    check("fl_still_empty", {id_ex_valid_1, id_ex_valid_2}, 2'b00);
    stall_bus_2 = 0;
    drive1(1, 32'h66, 64'h50, 0);
    step;
    check("mid_valid", id_ex_valid_1, 1);
    drive1(0, 0, 0, 0);
    #2 reset = 0;
    #1;
    check("mid_rst_valid", id_ex_valid_1, 0);
    check("mid_rst_ir", id_ex_IR_1, NOP);
    check("mid_rst_ready", id_ready_1, 1);
    check("mid_rst_sc1", stall_cycles_1, 0);
    reset = 1;
    drive1(1, 32'h77, 64'h54, 0);
    step;
    check("post_rst_accept", id_ex_IR_1, 64'h77);
    stall_bus_1 = 0;
    drive1(0, 0, 0, 0);
    step;
    check("post_rst_drain", id_ex_valid_1, 0);
    stall_bus_2 = 1;
    drive2(1, 32'h99, 64'h60);
    step;
    drive2(0, 0, 0);
    repeat (5) step;
    check("sc2_five", stall_cycles_2, SC5);
    check("sc1_zero", stall_cycles_1, 0);
    check("sc_head_held", id_ex_IR_2, 64'h99);
    stall_bus_2 = 0;
    ex_branch_taken = 1;
    step;
    ex_branch_taken = 0;
    check("sc_flush_empty", id_ex_valid_2, 0);
    check("sc2_after_flush", stall_cycles_2, SC5);
    #2 reset = 0;
    #1;
    check("sc2_reset", stall_cycles_2, 0);
    reset = 1;
    step;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
